// File: rtl/psa_pkg.sv
// Shared constants for the pattern-search block: memory geometry and the
// loader state encoding. The searcher reuses the geometry constants.
package psa_pkg;

  localparam int PSA_ADDR_W = 8;
  localparam int PSA_DATA_W = 8;
  localparam int PSA_DEPTH  = 251;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } psa_state_t;

endpackage

// File: rtl/psa_wr_port.sv
// BRAM write port for the block loader: turns an accept strobe plus the
// extended target address into one registered write cycle, and flags
// addresses beyond the last valid word so they are never written.
module psa_wr_port
  import psa_pkg::*;
#(
  parameter int ADDR_W = PSA_ADDR_W,
  parameter int DATA_W = PSA_DATA_W,
  parameter int DEPTH  = PSA_DEPTH
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              acc_vld_p0,
  input  logic [ADDR_W:0]   addr_p0,
  input  logic [DATA_W-1:0] din_p0,
  output logic              range_err,
  output logic              wr_ok,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din
);

  // Compared at full ADDR_W+1 width so a carry out of base+count is caught
  // instead of wrapping to a low address.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  assign range_err = addr_p0 > LAST_ADDR;
  assign wr_ok     = acc_vld_p0 && !range_err;

  // p0 -> p1: register one write cycle per in-range accepted byte
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_en <= wr_ok;
      mem_we <= wr_ok;
      if (wr_ok) begin
        mem_addr <= addr_p0[ADDR_W-1:0];
        mem_din  <= din_p0;
      end
    end
  end

endmodule

// File: rtl/psa_block_loader.sv
// Pattern-search block loader: writes a valid/ready byte stream into the
// search BRAM from a programmable base and reports the stored length.
// Optional build macro PSA_LOADER_CHECKSUM_EN adds an 8-bit wrapping sum
// of all bytes written (output checksum).
module psa_block_loader
  import psa_pkg::*;
#(
  parameter int ADDR_W = PSA_ADDR_W,
  parameter int DATA_W = PSA_DATA_W,
  parameter int DEPTH  = PSA_DEPTH
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   max_len,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   loaded_len,
  output logic              overflow
`ifdef PSA_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  psa_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   max_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W:0]   addr_p0;
  logic              accept;
  logic              start_ok;
  logic              blk_end;
  logic              range_err;
  logic              wr_ok;

  assign in_ready  = (state_q == ST_LOAD) && !hold;
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q != ST_LOAD);
  assign count_nxt = count_q + (ADDR_W+1)'(1);
  assign addr_p0   = {1'b0, base_q} + count_q;
  // Any one of these closes the block; they may coincide on one byte.
  assign blk_end   = range_err || in_last || (count_nxt == max_q);
  assign busy      = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_DONE);

  psa_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_wr_port (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .acc_vld_p0 (accept),
    .addr_p0    (addr_p0),
    .din_p0     (in_data),
    .range_err  (range_err),
    .wr_ok      (wr_ok),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din)
  );

  // State register
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start is honoured only outside LOAD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (max_len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && blk_end) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load bookkeeping: latched parameters, write count, result length, overflow
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      base_q     <= '0;
      max_q      <= '0;
      count_q    <= '0;
      loaded_len <= '0;
      overflow   <= 1'b0;
    end else if (start_ok) begin
      base_q     <= base_addr;
      max_q      <= max_len;
      count_q    <= '0;
      loaded_len <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      if (wr_ok)     count_q  <= count_nxt;
      if (range_err) overflow <= 1'b1;
      // A rejected byte is not counted in the reported length
      if (blk_end)   loaded_len <= range_err ? count_q : count_nxt;
    end
  end

`ifdef PSA_LOADER_CHECKSUM_EN
  // Running sum tracks exactly the bytes that reach the BRAM
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (wr_ok)    checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_psa_block_loader.sv
// Directed bench for psa_block_loader with hand-computed expectations.
module tb_psa_block_loader;

  logic       CLK100MHZ;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] max_len;
  logic       hold;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       busy;
  logic       load_done;
  logic [8:0] loaded_len;
  logic       overflow;
`ifdef PSA_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  psa_block_loader dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .max_len    (max_len),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .load_done  (load_done),
    .loaded_len (loaded_len),
    .overflow   (overflow)
`ifdef PSA_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Log every BRAM write, sampled mid-cycle
  always @(negedge CLK100MHZ) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_din);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] m);
    start = 1'b1; base_addr = b; max_len = m;
    @(posedge CLK100MHZ); #1;
    start = 1'b0;
  endtask

  // Present one byte and wait up to budget cycles for it to be taken
  task automatic send(input logic [7:0] d, input logic last, input int budget, output logic ok);
    in_valid = 1'b1; in_data = d; in_last = last; ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(negedge CLK100MHZ);
      if (in_ready) ok = 1'b1;
      @(posedge CLK100MHZ); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Send a byte that must be accepted and appear as a write one cycle later
  task automatic send_chk(input string tag, input logic [7:0] d, input logic last,
                          input logic [7:0] exp_addr);
    logic ok;
    send(d, last, 8, ok);
    chk({tag, "_acc"}, 32'(ok), 32'd1);
    chk({tag, "_wr"}, 32'({mem_en, mem_we, mem_addr, mem_din}), 32'({2'b11, exp_addr, d}));
  endtask

  task automatic settle();
    repeat (2) @(posedge CLK100MHZ);
    #1;
  endtask

  initial begin
    logic ok;
    reset = 1'b0; start = 1'b0; base_addr = '0; max_len = '0; hold = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;

    // Reset state
    #23;
    chk("rst_ctl", 32'({in_ready, mem_en, mem_we, busy, load_done, overflow}), 32'd0);
    chk("rst_data", 32'({mem_addr, mem_din, loaded_len}), 32'd0);
`ifdef PSA_LOADER_CHECKSUM_EN
    chk("rst_csum", 32'(checksum), 32'd0);
`endif
    @(posedge CLK100MHZ); #1;
    reset = 1'b1;
    @(posedge CLK100MHZ); #1;
    chk("idle_rdy", 32'(in_ready), 32'd0);

    // Basic load
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(8'd0, 9'd4);
    chk("t1_busy", 32'({busy, load_done, in_ready}), 32'b101);
    send_chk("t1_b0", 8'h11, 1'b0, 8'd0);
    send_chk("t1_b1", 8'h22, 1'b0, 8'd1);
    send_chk("t1_b2", 8'h33, 1'b0, 8'd2);
    send_chk("t1_b3", 8'h44, 1'b1, 8'd3);
    chk("t1_done", 32'({load_done, busy, in_ready, overflow}), 32'b1000);
    chk("t1_len", 32'(loaded_len), 32'd4);
    @(posedge CLK100MHZ); #1;
    chk("t1_we_pulse", 32'({mem_en, mem_we}), 32'd0);
    settle();
    chk("t1_nwr", 32'(wr_addr_q.size()), 32'd4);

    // Length cap
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(8'd10, 9'd3);
    chk("t2_len_clr", 32'({loaded_len, load_done}), 32'd0);
    send_chk("t2_b0", 8'h51, 1'b0, 8'd10);
    send_chk("t2_b1", 8'h52, 1'b0, 8'd11);
    send_chk("t2_b2", 8'h53, 1'b0, 8'd12);
    chk("t2_rdy", 32'(in_ready), 32'd0);
    chk("t2_done", 32'({load_done, loaded_len}), 32'({1'b1, 9'd3}));
    send(8'h54, 1'b0, 4, ok);
    chk("t2_b3_rej", 32'(ok), 32'd0);
    send(8'h55, 1'b0, 4, ok);
    chk("t2_b4_rej", 32'(ok), 32'd0);
    chk("t2_nwr", 32'(wr_addr_q.size()), 32'd3);

    // Overflow at the top of the memory
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(8'd249, 9'd5);
    send_chk("t3_b0", 8'hA0, 1'b0, 8'd249);
    send_chk("t3_b1", 8'hA1, 1'b0, 8'd250);
    send(8'hA2, 1'b0, 8, ok);
    chk("t3_b2_acc", 32'(ok), 32'd1);
    chk("t3_no_wr", 32'({mem_en, mem_we}), 32'd0);
    chk("t3_ovf", 32'({overflow, load_done, busy}), 32'b110);
    chk("t3_len", 32'(loaded_len), 32'd2);
    send(8'hA3, 1'b0, 4, ok);
    chk("t3_b3_rej", 32'(ok), 32'd0);
    chk("t3_nwr", 32'(wr_addr_q.size()), 32'd2);

    // Hold stall mid-load
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(8'd20, 9'd6);
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    send_chk("t4_b0", 8'h61, 1'b0, 8'd20);
    send_chk("t4_b1", 8'h62, 1'b0, 8'd21);
    send_chk("t4_b2", 8'h63, 1'b0, 8'd22);
    hold = 1'b1; in_valid = 1'b1; in_data = 8'h64;
    #1;
    chk("t4_hold_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK100MHZ); #1;
      chk("t4_stall", 32'({in_ready, mem_we}), 32'd0);
    end
    hold = 1'b0;
    send_chk("t4_b3", 8'h64, 1'b0, 8'd23);
    send_chk("t4_b4", 8'h65, 1'b0, 8'd24);
    send_chk("t4_b5", 8'h66, 1'b1, 8'd25);
    chk("t4_done", 32'({load_done, loaded_len}), 32'({1'b1, 9'd6}));
    settle();
    chk("t4_nwr", 32'(wr_addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("t4_order", 32'({wr_addr_q[i], wr_data_q[i]}), 32'({8'(20 + i), 8'(8'h61 + i)}));

    // Zero-length start
    do_start(8'd50, 9'd0);
    chk("t5_zero", 32'({load_done, busy, loaded_len}), 32'({2'b10, 9'd0}));

    // Start during LOAD is ignored
    do_start(8'd30, 9'd4);
    send_chk("t5_b0", 8'h71, 1'b0, 8'd30);
    send_chk("t5_b1", 8'h72, 1'b0, 8'd31);
    do_start(8'd100, 9'd1);
    chk("t5_still_busy", 32'({busy, load_done}), 32'b10);
    send_chk("t5_b2", 8'h73, 1'b0, 8'd32);
    send_chk("t5_b3", 8'h74, 1'b1, 8'd33);
    chk("t5_len", 32'({load_done, loaded_len}), 32'({1'b1, 9'd4}));

    // Asynchronous reset mid-load
    do_start(8'd40, 9'd5);
    send_chk("t6_b0", 8'h81, 1'b0, 8'd40);
    send_chk("t6_b1", 8'h82, 1'b0, 8'd41);
    reset = 1'b0;
    #1;
    chk("t6_rst_ctl", 32'({in_ready, mem_en, mem_we, busy, load_done, overflow}), 32'd0);
    chk("t6_rst_data", 32'({mem_addr, mem_din, loaded_len}), 32'd0);
    @(negedge CLK100MHZ);
    reset = 1'b1;
    @(posedge CLK100MHZ); #1;
    chk("t6_idle", 32'({busy, load_done, in_ready}), 32'd0);

`ifdef PSA_LOADER_CHECKSUM_EN
    // Checksum wraps at 8 bits: 0xFF + 0x02 = 0x01
    do_start(8'd0, 9'd2);
    chk("t7_csum_clr", 32'(checksum), 32'd0);
    send_chk("t7_b0", 8'hFF, 1'b0, 8'd0);
    send_chk("t7_b1", 8'h02, 1'b1, 8'd1);
    chk("t7_csum", 32'({load_done, checksum}), 32'({1'b1, 8'h01}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
